// File: rtl/dct_coef_engine.sv
// dct_coef_engine: one DCT coefficient X[k] of an N-sample frame by serial multiply-accumulate.
// Latency: out_valid rises N enabled cycles after accept (N/2 when DCT_SYMMETRY_EN is defined).
// Backpressure: in_ready low in MAC/DONE; result held until out_ready; en=0 freezes all state.
module dct_coef_engine #(
    parameter int N  = 8,
    parameter int DW = 8,
    parameter int CW = 16,
    parameter int KW = $clog2(N),
    parameter int OW = DW + CW + $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*DW-1:0] in_data,
    input  logic [KW-1:0]   k_sel,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OW-1:0]   out_data,
    output logic            busy
);

    localparam int CNTW = $clog2(N);
`ifdef DCT_SYMMETRY_EN
    // Even/odd folding halves the tap count: C[k][N-1-n] = (-1)^k * C[k][n].
    localparam int TAPS = N / 2;
`else
    localparam int TAPS = N;
`endif
    localparam logic [CNTW-1:0] LAST_TAP = CNTW'(TAPS - 1);

    // The quarter-wave table is held at 14 fractional bits; other CW values rescale it.
    localparam int SCL_L = (CW >= 16) ? CW - 16 : 0;
    localparam int SCL_R = (CW < 16) ? 16 - CW : 0;

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

    state_t                state_q;
    logic                  idle_q;
    logic [N*DW-1:0]       frame_q;
    logic [KW-1:0]         k_q;
    logic [CNTW-1:0]       cnt_q;
    logic signed [OW-1:0]  acc_q;
    logic                  out_valid_q;
    logic [OW-1:0]         out_data_q;
    logic                  busy_q;

    logic signed [DW-1:0]  x_lo_d;
`ifdef DCT_SYMMETRY_EN
    logic signed [DW-1:0]  x_hi_d;
`endif
    logic signed [DW:0]    opnd_d;
    logic signed [CW-1:0]  coef_d;
    logic signed [DW+CW:0] prod_d;
    logic signed [OW-1:0]  acc_d;

    // cos(pi*j/32) * 2^14 for j = 0..16; N = 4 and 8 use every 4th / 2nd entry.
    function automatic int qtab_f(input int j);
        case (j)
            0:       return 16384;
            1:       return 16305;
            2:       return 16069;
            3:       return 15679;
            4:       return 15137;
            5:       return 14449;
            6:       return 13623;
            7:       return 12665;
            8:       return 11585;
            9:       return 10394;
            10:      return 9102;
            11:      return 7723;
            12:      return 6270;
            13:      return 4756;
            14:      return 3196;
            15:      return 1606;
            default: return 0;
        endcase
    endfunction

    // C[k][n]: fold the phase (2n+1)k into the first quadrant, then look up and sign.
    function automatic logic signed [CW-1:0] coef_f(input logic [KW-1:0] k,
                                                    input logic [CNTW-1:0] n);
        int   m;
        int   j;
        int   v;
        logic neg;
        m = ((2 * int'(n) + 1) * int'(k)) % (4 * N);
        j = m * (16 / N);
        if (j > 32) j = 64 - j;
        neg = (j > 16);
        if (neg) j = 32 - j;
        v = qtab_f(j);
        if (CW >= 16) v = v <<< SCL_L;
        else          v = (v + ((1 <<< SCL_R) >>> 1)) >>> SCL_R;
        if (neg) v = -v;
        return v[CW-1:0];
    endfunction

    // Tap operand selection, coefficient lookup and full-precision product/accumulate.
    always_comb begin
        x_lo_d = frame_q[int'(cnt_q)*DW +: DW];
`ifdef DCT_SYMMETRY_EN
        x_hi_d = frame_q[(N - 1 - int'(cnt_q))*DW +: DW];
        if (k_q[0]) opnd_d = {x_lo_d[DW-1], x_lo_d} - {x_hi_d[DW-1], x_hi_d};
        else        opnd_d = {x_lo_d[DW-1], x_lo_d} + {x_hi_d[DW-1], x_hi_d};
`else
        opnd_d = {x_lo_d[DW-1], x_lo_d};
`endif
        coef_d = coef_f(k_q, cnt_q);
        prod_d = $signed({{CW{opnd_d[DW]}}, opnd_d}) *
                 $signed({{(DW+1){coef_d[CW-1]}}, coef_d});
        acc_d  = acc_q + {{(OW-DW-CW-1){prod_d[DW+CW]}}, prod_d};
    end

    // Control FSM with frame capture, MAC accumulator and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idle_q      <= 1'b1;
            frame_q     <= '0;
            k_q         <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
        end else if (en) begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        frame_q <= in_data;
                        k_q     <= k_sel;
                        cnt_q   <= '0;
                        acc_q   <= '0;
                        idle_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_MAC;
                    end
                end
                S_MAC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CNTW'(1);
                    if (cnt_q == LAST_TAP) begin
                        out_data_q  <= acc_d;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        idle_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Ready is withheld during reset and while the clock enable is low.
    assign in_ready  = idle_q & en & ~rst;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;

endmodule

// File: doc/dct_coef_engine.md
Name: dct_coef_engine

Overview:
- Parametrised successor of the fixed 8-point, fixed-index DCT coefficient slice in the EEG compression datapath.
- Accepts one N-sample frame through a valid/ready handshake and computes one DCT coefficient X[k] = sum over n of x[n]*C[k][n] with a sequential multiply-accumulate.
- The coefficient index k is selectable per frame, and the coefficient ROM is internal.
- Sits between the sample framer and the quantiser/entropy stage; one instance can replace the per-index slices.

Parameters:
- N, 8, transform length; supported values are 4, 8 and 16, each backed by a generated ROM case table.
- DW, 8, signed input sample width.
- CW, 16, signed coefficient width; coefficients are stored as round(cos(pi*(2n+1)*k/(2N)) * 2^(CW-2)).
- KW, $clog2(N), width of the coefficient-index select.
- OW, DW+CW+$clog2(N), signed output width.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  clock enable; when low, all state, counters and the accumulator hold.
- in_valid  in  1  frame present on in_data.
- in_ready  out  1  engine can accept a frame.
- in_data  in  N*DW  packed signed samples; x[n] occupies bits [n*DW +: DW].
- k_sel  in  KW  coefficient index; sampled together with in_data.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  OW  signed X[k].
- busy  out  1  high in MAC and DONE states.

Behaviour:
- Reset: state=IDLE, in_ready=0 during reset and 1 from the first cycle after reset (if en=1). out_valid=0, out_data=0, busy=0, accumulator=0, tap counter=0.
- States:
  - IDLE: in_ready=1. in_valid&in_ready&en latches in_data and k_sel into frame registers, clears the accumulator and counter, then goes to MAC.
  - MAC: one tap per enabled cycle, acc += sext(x[cnt])*C[k][cnt]; the counter increments. After tap N-1, out_data<=acc_final, out_valid<=1, then goes to DONE.
  - DONE: out_valid held and out_data stable until out_valid&out_ready&en; then goes to IDLE with out_valid=0 on the next edge.
- Latency: out_valid rises exactly N enabled cycles after the accepting edge.
- No bypass: in_ready is 0 in MAC and DONE. Throughput is one frame per N+2 cycles with out_ready tied high.
- Data stability: in_data and k_sel changes outside the accept edge have no effect. Inputs are registered at accept, so the upstream may change them immediately after.
- Arithmetic: full-precision signed products of DW+CW bits and an OW-bit accumulator. No rounding, truncation or saturation, so overflow is impossible for any input. Orthonormal scaling is not applied and belongs downstream.
- en low in any state freezes everything, including the DONE handshake (out_ready is ignored) and input acceptance.
- rst asserted mid-frame discards the frame immediately; outputs return to their reset values on the same edge.
- Simultaneous in_valid and out_ready while in DONE: only the output handshake completes; the new frame is accepted in IDLE on the following cycle.

Optional Feature:
- Macro: DCT_SYMMETRY_EN.
- Defined:
  - The MAC state pre-adds s=x[n]+x[N-1-n] for even k and d=x[n]-x[N-1-n] for odd k, using DW+1-bit operands.
  - Only the N/2 ROM entries for n<N/2 are used.
  - Latency becomes N/2 enabled cycles; throughput is one frame per N/2+2 cycles.
  - out_data is bit-identical to the non-symmetric build for all inputs.
- Undefined: plain N-tap serial MAC as described in Behaviour.

Test Plan (N=8, DW=8, CW=16; out_ready=1 and en=1 unless stated):
- All x=1, k_sel=0 -> out_data=131072 (8*16384); out_valid rises 8 cycles after accept (4 cycles with DCT_SYMMETRY_EN).
- All x=127, k_sel=0, then all x=-128, k_sel=0 back-to-back -> 16646144, then -16777216; in_ready low between frames; second accept occurs the cycle after the first output handshake.
- All x=100, k_sel=1..7 -> out_data=0 for every k (antisymmetric/cancelling rounded coefficients); exercise each k.
- x=[1,0,0,0,0,0,0,0], k_sel=1 -> out_data=C[1][0]=round(cos(pi/16)*16384)=16069. With out_ready low for 5 cycles, out_valid and out_data are held stable, and in_ready stays 0 until the handshake completes.
- en toggled low for 3 cycles mid-MAC -> result unchanged and latency extended by exactly 3 cycles. rst pulsed mid-MAC -> out_valid=0, out_data=0, in_ready=1 the next cycle, and no stale result emitted.
- Random frames and k_sel (1000 frames, random out_ready/en) against a reference model -> exact match. Build with and without DCT_SYMMETRY_EN and compare outputs bit-exactly.
